// File: rtl/qea_host_sequencer.sv
// qea_host_sequencer: streams gate contexts into the QEA context RAM, initialises
// the state RAM to |0..0>, starts the core, times the run, then reads every
// state row back out on a valid/ready stream.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a legal i_go
// LOAD_CTX | accepting context beats, one RAM write per accepted beat
// INIT     | writing ROWS state rows, row 0 = |0..0> amplitude 1.0
// START    | one-cycle start pulse to the core, run counter cleared
// RUN      | counting cycles until the core reports completion
// RD_ISSUE | one-cycle read request for the current row
// RD_WAIT  | waiting out the state RAM read latency
// RD_OUT   | row presented on the result stream until accepted
// DONE     | one-cycle completion pulse
module qea_host_sequencer #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int RD_LAT                  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
    input  logic                                 s_ctx_valid,
    output logic                                 s_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   s_ctx_data,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic                                 o_state_ena,
    output logic                                 o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    output logic                                 o_qea_start,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_dout,
    output logic                                 m_st_valid,
    input  logic                                 m_st_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   m_st_data,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_err,
    output logic [31:0]                          o_exec_cycles
);

    localparam int ROW_W = PE_NUM * STATE_DATA_WIDTH;
    localparam int CNT_W = GATE_CONTEXT_ADDR_WIDTH + 1;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    // Top lane carries {re = 1.0, im = 0}; all lower lanes are zero amplitude.
    localparam logic [ROW_W-1:0] INIT_ROW0 = {
        (DATA_WIDTH'(1) << NUM_FRAC_BIT),
        DATA_WIDTH'(0),
        {((PE_NUM - 1) * STATE_DATA_WIDTH){1'b0}}
    };

    typedef enum logic [3:0] {
        IDLE,
        LOAD_CTX,
        INIT,
        START,
        RUN,
        RD_ISSUE,
        RD_WAIT,
        RD_OUT,
        DONE
    } state_t;

    state_t                      state;
    state_t                      state_next;

    logic [CNT_W-1:0]            ins_num_r;
    logic [CNT_W-1:0]            ctx_cnt;
    logic [STATE_ADDR_WIDTH-1:0] last_row;
    logic [STATE_ADDR_WIDTH-1:0] row;
    logic [STATE_ADDR_WIDTH-1:0] row_next;
    logic [LAT_W-1:0]            lat_cnt;
    logic [31:0]                 cyc_cnt;

    logic                        qbit_legal;
    logic                        go_ok;
    logic [MAX_QBIT_WIDTH-1:0]   row_shift;
    logic [STATE_ADDR_WIDTH:0]   rows_full;
    logic [STATE_ADDR_WIDTH-1:0] last_row_d;
    logic                        ctx_fire;
    logic                        ctx_last;
    logic                        row_last;
    logic                        st_fire;
    logic                        rd_capture;
    logic [31:0]                 cyc_inc;
    logic                        state_ram_active;

    assign qbit_legal = (i_qbit_num >= MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) &&
                        (i_qbit_num <= MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH));
    assign go_ok      = (state == IDLE) && i_go && qbit_legal;

    // Row count is a power of two; only the last row index is kept.
    assign row_shift  = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    assign rows_full  = (STATE_ADDR_WIDTH + 1)'(1) << row_shift;
    assign last_row_d = STATE_ADDR_WIDTH'(rows_full - (STATE_ADDR_WIDTH + 1)'(1));

    // s_ctx_ready is only ever high in LOAD_CTX, so a fire implies that state.
    assign ctx_fire   = s_ctx_valid && s_ctx_ready;
    assign ctx_last   = (ctx_cnt == ins_num_r - CNT_W'(1));
    assign row_last   = (row == last_row);
    assign st_fire    = m_st_valid && m_st_ready;
    assign rd_capture = (state == RD_WAIT) && (lat_cnt == LAT_W'(RD_LAT - 1));
    assign cyc_inc    = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 32'd1;

    assign state_ram_active = (state_next == INIT) || (state_next == RD_ISSUE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and row-pointer decode.
    always_comb begin
        state_next = state;
        row_next   = row;
        case (state)
            IDLE: begin
                if (go_ok) begin
                    row_next   = '0;
                    state_next = (i_ins_num == '0) ? INIT : LOAD_CTX;
                end
            end
            LOAD_CTX: begin
                if (ctx_fire && ctx_last) begin
                    row_next   = '0;
                    state_next = INIT;
                end
            end
            INIT: begin
                if (row_last) begin
                    row_next   = '0;
                    state_next = START;
                end else begin
                    row_next = row + STATE_ADDR_WIDTH'(1);
                end
            end
            START: begin
                state_next = RUN;
            end
            RUN: begin
                if (i_qea_complete) begin
                    row_next   = '0;
                    state_next = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (rd_capture) begin
                    state_next = RD_OUT;
                end
            end
            RD_OUT: begin
                if (st_fire) begin
                    if (row_last) begin
                        state_next = DONE;
                    end else begin
                        row_next   = row + STATE_ADDR_WIDTH'(1);
                        state_next = RD_ISSUE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Job parameters and internal counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_num_r <= '0;
            last_row  <= '0;
            ctx_cnt   <= '0;
            row       <= '0;
            lat_cnt   <= '0;
            cyc_cnt   <= '0;
        end else begin
            row <= row_next;
            if (go_ok) begin
                ins_num_r <= i_ins_num;
                last_row  <= last_row_d;
                ctx_cnt   <= '0;
            end else if (ctx_fire) begin
                ctx_cnt <= ctx_cnt + CNT_W'(1);
            end
            lat_cnt <= (state == RD_WAIT) ? lat_cnt + LAT_W'(1) : '0;
            if (state == START) begin
                cyc_cnt <= '0;
            end else if (state == RUN) begin
                cyc_cnt <= cyc_inc;
            end
        end
    end

    // Context RAM write port: one registered write per accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ctx_ready <= 1'b0;
            o_ctx_en    <= 1'b0;
            o_ctx_wea   <= 1'b0;
            o_ctx_addr  <= '0;
            o_ctx_data  <= '0;
        end else begin
            s_ctx_ready <= (state_next == LOAD_CTX);
            o_ctx_en    <= ctx_fire;
            o_ctx_wea   <= ctx_fire;
            if (ctx_fire) begin
                o_ctx_addr <= ctx_cnt[GATE_CONTEXT_ADDR_WIDTH-1:0];
                o_ctx_data <= s_ctx_data;
            end
        end
    end

    // State RAM port: init writes and readout requests, aligned with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_state_ena   <= 1'b0;
            o_state_wea   <= 1'b0;
            o_state_addra <= '0;
            o_state_dina  <= '0;
        end else begin
            o_state_ena <= state_ram_active;
            o_state_wea <= (state_next == INIT);
            if (state_ram_active) begin
                o_state_addra <= row_next;
            end
            o_state_dina <= ((state_next == INIT) && (row_next == '0)) ? INIT_ROW0 : '0;
        end
    end

    // Core control, run timing, result stream and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_qea_start   <= 1'b0;
            o_exec_cycles <= '0;
            m_st_valid    <= 1'b0;
            m_st_data     <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_qea_start <= (state_next == START);
            if ((state == RUN) && i_qea_complete) begin
                o_exec_cycles <= cyc_inc;
            end
            if (rd_capture) begin
                m_st_data <= i_qea_dout;
            end
            m_st_valid <= (state_next == RD_OUT);
            o_busy     <= (state_next != IDLE);
            o_done     <= (state_next == DONE);
            o_err      <= (state == IDLE) && i_go && !qbit_legal;
        end
    end

endmodule
